// File: rtl/rps_move_capture_if.sv
// Round handshake between the move-capture front end (master) and the judge (slave).
// The master presents both one-hot moves with a level round_valid and holds them until round_ack.
interface rps_move_capture_if;
    logic       round_valid;
    logic       round_ack;
    logic [2:0] move1;
    logic [2:0] move2;
    logic [3:0] round_cnt;

    modport master (
        output round_valid,
        output move1,
        output move2,
        output round_cnt,
        input  round_ack
    );

    modport slave (
        input  round_valid,
        input  move1,
        input  move2,
        input  round_cnt,
        output round_ack
    );
endinterface

// File: rtl/rps_move_capture.sv
// Rock-paper-scissors front end: synchronise and debounce both players' buttons, latch one hidden move each, reveal to the judge.
// Optional RPS_CPU_P2_EN: player 2 is replaced by an 8-bit LFSR that locks together with player 1.
module rps_move_capture #(
    parameter int         DB_CYCLES = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic rock1,
    input  logic paper1,
    input  logic scissors1,
    input  logic lock1,
    input  logic rock2,
    input  logic paper2,
    input  logic scissors2,
    input  logic lock2,
    output logic p1_locked,
    output logic p2_locked,
    output logic err1,
    output logic err2,
    rps_move_capture_if.master rnd
);
    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REVEAL  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Raw bit order: {lock2, scissors2, paper2, rock2, lock1, scissors1, paper1, rock1}
    logic [7:0] raw;
`ifdef RPS_CPU_P2_EN
    assign raw = {4'b0000, lock1, scissors1, paper1, rock1};
`else
    assign raw = {lock2, scissors2, paper2, rock2, lock1, scissors1, paper1, rock1};
`endif

    logic [7:0]    sync1_q;
    logic [7:0]    sync2_q;
    logic [7:0]    deb_q;
    logic [7:0]    deb_d;
    logic [CW-1:0] db_cnt_q [8];
    logic [CW-1:0] db_cnt_d [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
            assign deb_d[gi]    = (sync2_q[gi] != deb_q[gi] && db_cnt_q[gi] == CNT_LAST)
                                  ? ~deb_q[gi] : deb_q[gi];
            assign db_cnt_d[gi] = (sync2_q[gi] == deb_q[gi] || db_cnt_q[gi] == CNT_LAST)
                                  ? '0 : db_cnt_q[gi] + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    logic [1:0] lock_prev_q;
    logic [2:0] btn1;
    logic       press1;
    logic       valid1;
    logic       release_ok;

    assign btn1   = deb_q[2:0];
    assign press1 = deb_q[3] & ~lock_prev_q[0];
    assign valid1 = (btn1 == 3'b001) || (btn1 == 3'b010) || (btn1 == 3'b100);

`ifdef RPS_CPU_P2_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] cpu_idx;
    logic [2:0] cpu_move;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting towards the MSB
    assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cpu_idx    = lfsr_q % 8'd3;
    assign release_ok = ~deb_q[3];

    always_comb begin
        case (cpu_idx)
            8'd0:    cpu_move = 3'b001;
            8'd1:    cpu_move = 3'b010;
            default: cpu_move = 3'b100;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    logic [2:0] btn2;
    logic       press2;
    logic       valid2;

    assign btn2       = deb_q[6:4];
    assign press2     = deb_q[7] & ~lock_prev_q[1];
    assign valid2     = (btn2 == 3'b001) || (btn2 == 3'b010) || (btn2 == 3'b100);
    assign release_ok = ~deb_q[3] & ~deb_q[7];
`endif

    state_t     state_q, state_d;
    logic       lock1_q, lock1_d;
    logic       lock2_q, lock2_d;
    logic [2:0] sel1_q, sel1_d;
    logic [2:0] sel2_q, sel2_d;
    logic       err1_q, err1_d;
    logic       err2_q, err2_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rv_q, rv_d;
    logic [2:0] mv1_out_q, mv1_out_d;
    logic [2:0] mv2_out_q, mv2_out_d;

    always_ff @(posedge clk) begin : state_register
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin : next_state_logic
        state_d = state_q;
        case (state_q)
            COLLECT: if (lock1_q && lock2_q) state_d = REVEAL;
            REVEAL:  if (rnd.round_ack)      state_d = RELEASE;
            RELEASE: if (release_ok)         state_d = COLLECT;
            default:                         state_d = COLLECT;
        endcase
    end

    always_comb begin : round_datapath
        lock1_d = lock1_q;
        lock2_d = lock2_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        err1_d  = 1'b0;
        err2_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == COLLECT) begin
            if (press1 && !lock1_q) begin
                if (valid1) begin
                    lock1_d = 1'b1;
                    sel1_d  = btn1;
`ifdef RPS_CPU_P2_EN
                    lock2_d = 1'b1;
                    sel2_d  = cpu_move;
`endif
                end else begin
                    err1_d = 1'b1;
                end
            end
`ifndef RPS_CPU_P2_EN
            if (press2 && !lock2_q) begin
                if (valid2) begin
                    lock2_d = 1'b1;
                    sel2_d  = btn2;
                end else begin
                    err2_d = 1'b1;
                end
            end
`endif
        end
        if (state_q == REVEAL && rnd.round_ack) begin
            cnt_d   = cnt_q + 4'd1;
            lock1_d = 1'b0;
            lock2_d = 1'b0;
            sel1_d  = 3'b000;
            sel2_d  = 3'b000;
        end
    end

    // Outputs are decoded from next state so they switch on the same edge as the state
    always_comb begin : output_decode
        rv_d      = (state_d == REVEAL);
        mv1_out_d = rv_d ? sel1_d : 3'b000;
        mv2_out_d = rv_d ? sel2_d : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_prev_q <= '0;
            lock1_q     <= 1'b0;
            lock2_q     <= 1'b0;
            sel1_q      <= '0;
            sel2_q      <= '0;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
            cnt_q       <= '0;
            rv_q        <= 1'b0;
            mv1_out_q   <= '0;
            mv2_out_q   <= '0;
        end else begin
            lock_prev_q <= {deb_q[7], deb_q[3]};
            lock1_q     <= lock1_d;
            lock2_q     <= lock2_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            err1_q      <= err1_d;
            err2_q      <= err2_d;
            cnt_q       <= cnt_d;
            rv_q        <= rv_d;
            mv1_out_q   <= mv1_out_d;
            mv2_out_q   <= mv2_out_d;
        end
    end

    assign p1_locked       = lock1_q;
    assign p2_locked       = lock2_q;
    assign err1            = err1_q;
    assign err2            = err2_q;
    assign rnd.round_valid = rv_q;
    assign rnd.move1       = mv1_out_q;
    assign rnd.move2       = mv2_out_q;
    assign rnd.round_cnt   = cnt_q;
endmodule
